bat_powerup_ctrl: RTL and testbench



---
 rtl/bricks_pkg.sv | 31 +++
 rtl/frame_countdown.sv | 32 +++
 rtl/bat_powerup_ctrl.sv | 133 +++++++++++++
 tb/tb_bat_powerup_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bricks_pkg.sv
// Shared types and constants for the bat datapath: controller state encoding,
// frame-counter width and length-code helpers.
package bricks_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        GROWN  = 2'd1,
        SHRUNK = 2'd2,
        FREEZE = 2'd3
    } bat_state_t;

    localparam int BAT_BASE_WIDTH = 27;
    localparam int FRAME_CNT_W    = 10;

    // Clamp a signed 4-bit length intermediate into the legal code range.
    function automatic logic [2:0] sat_len(input logic signed [3:0] v,
                                           input int lo, input int hi);
        if (v < lo)
            return 3'(lo);
        else if (v > hi)
            return 3'(hi);
        else
            return v[2:0];
    endfunction

    // Pixel width of the bat for a given length code.
    function automatic int bat_width(input logic [2:0] len);
        return BAT_BASE_WIDTH << (len / 2);
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter shared by power-up and freeze timing; load wins
// over tick, the count sticks at zero, expire_pulse flags the 1->0 step.
import bricks_pkg::*;

module frame_countdown (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [FRAME_CNT_W-1:0] load_val,
    input  logic                   tick,
    output logic [FRAME_CNT_W-1:0] count,
    output logic                   expire_pulse
);

    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

    logic [FRAME_CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else if (load)
            count_reg <= load_val;
        else if (tick && count_reg != '0)
            count_reg <= count_reg - CNT_ONE;
    end

    // Combinational so the owner can change state on the same edge the count hits 0.
    assign expire_pulse = tick & ~load & (count_reg == CNT_ONE);
    assign count        = count_reg;

endmodule

// File: rtl/bat_powerup_ctrl.sv
// Bat length / key-gating controller with timed grow, shrink and post-miss freeze.
// Define POWERUP_STACK_EN for relative, stacking power-ups.
import bricks_pkg::*;

module bat_powerup_ctrl #(
    parameter int DEFAULT_LEN    = 2,
    parameter int MIN_LEN        = 0,
    parameter int MAX_LEN        = 4,
    parameter int POWERUP_FRAMES = 300,
    parameter int FREEZE_FRAMES  = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   right,
    input  logic                   left,
    input  logic                   grow,
    input  logic                   shrink,
    input  logic                   ball_lost,
    input  logic                   level_restart,
    output logic [2:0]             bat_length,
    output logic                   right_out,
    output logic                   left_out,
    output logic                   frozen,
    output logic                   powerup_active,
    output logic [FRAME_CNT_W-1:0] frames_left
);

    localparam logic [2:0]             DEF_LEN    = 3'(DEFAULT_LEN);
    localparam logic [FRAME_CNT_W-1:0] PU_LOAD    = FRAME_CNT_W'(POWERUP_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] FRZ_LOAD   = FRAME_CNT_W'(FREEZE_FRAMES);

    bat_state_t state_reg, state_next;
    logic [2:0] len_reg, len_next;
    logic       right_reg, left_reg;

    logic                   cnt_load;
    logic [FRAME_CNT_W-1:0] cnt_load_val;
    logic                   cnt_expire;
    logic [FRAME_CNT_W-1:0] cnt_value;

    logic signed [3:0]      len_base;
    logic signed [3:0]      len_delta;
    logic signed [3:0]      len_sum;
    logic [2:0]             len_sat;
    logic [FRAME_CNT_W-1:0] pu_timer;

    frame_countdown u_countdown (
        .clk          (clk),
        .reset        (reset),
        .load         (cnt_load),
        .load_val     (cnt_load_val),
        .tick         (startOfFrame),
        .count        (cnt_value),
        .expire_pulse (cnt_expire)
    );

`ifdef POWERUP_STACK_EN
    logic [FRAME_CNT_W:0] stack_sum;

    assign len_base  = signed'({1'b0, len_reg});
    assign stack_sum = {1'b0, cnt_value} + {1'b0, PU_LOAD};
    // Carry out of the 10-bit sum means the total passed 1023.
    assign pu_timer  = stack_sum[FRAME_CNT_W] ? '1 : stack_sum[FRAME_CNT_W-1:0];
`else
    assign len_base  = signed'({1'b0, DEF_LEN});
    assign pu_timer  = PU_LOAD;
`endif

    assign len_delta = grow ? 4'sd2 : -4'sd2;
    assign len_sum   = len_base + len_delta;
    assign len_sat   = sat_len(len_sum, MIN_LEN, MAX_LEN);

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        if (level_restart) begin
            state_next = NORMAL;
            len_next   = DEF_LEN;
            cnt_load   = 1'b1;
        end else if (ball_lost) begin
            state_next   = FREEZE;
            len_next     = DEF_LEN;
            cnt_load     = 1'b1;
            cnt_load_val = FRZ_LOAD;
        end else if ((grow ^ shrink) && state_reg != FREEZE) begin
            len_next     = len_sat;
            cnt_load     = 1'b1;
            cnt_load_val = pu_timer;
`ifdef POWERUP_STACK_EN
            if (len_sat > DEF_LEN)
                state_next = GROWN;
            else if (len_sat < DEF_LEN)
                state_next = SHRUNK;
            else begin
                state_next   = NORMAL;
                cnt_load_val = '0;
            end
`else
            state_next = grow ? GROWN : SHRUNK;
`endif
        end else if (cnt_expire) begin
            state_next = NORMAL;
            len_next   = DEF_LEN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= NORMAL;
            len_reg   <= DEF_LEN;
            right_reg <= 1'b0;
            left_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            // Keys follow the state being entered so they never leak into a freeze.
            right_reg <= (state_next != FREEZE) & ~level_restart & right & ~left;
            left_reg  <= (state_next != FREEZE) & ~level_restart & left & ~right;
        end
    end

    assign bat_length     = len_reg;
    assign right_out      = right_reg;
    assign left_out       = left_reg;
    assign frozen         = (state_reg == FREEZE);
    assign powerup_active = (state_reg == GROWN) || (state_reg == SHRUNK);
    assign frames_left    = cnt_value;

endmodule

// File: tb/tb_bat_powerup_ctrl.sv
// Directed bench for bat_powerup_ctrl; expectations adapt when POWERUP_STACK_EN is defined.
module tb_bat_powerup_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame, right, left, grow, shrink, ball_lost, level_restart;
    logic [2:0] bat_length;
    logic       right_out, left_out, frozen, powerup_active;
    logic [9:0] frames_left;

    int n_tests = 0;
    int n_fail  = 0;

    bat_powerup_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .right          (right),
        .left           (left),
        .grow           (grow),
        .shrink         (shrink),
        .ball_lost      (ball_lost),
        .level_restart  (level_restart),
        .bat_length     (bat_length),
        .right_out      (right_out),
        .left_out       (left_out),
        .frozen         (frozen),
        .powerup_active (powerup_active),
        .frames_left    (frames_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            cyc();
            startOfFrame = 1'b0;
            cyc();
        end
    endtask

    task automatic check_len_timer(input string tag, input int len, input int tmr, input int act);
        check({tag, " len"}, 32'(bat_length), 32'(len));
        check({tag, " timer"}, 32'(frames_left), 32'(tmr));
        check({tag, " active"}, 32'(powerup_active), 32'(act));
    endtask

    initial begin
        reset = 1'b1;
        {startOfFrame, right, left, grow, shrink, ball_lost, level_restart} = '0;
        cyc();
        cyc();
        check_len_timer("reset", 2, 0, 0);
        check("reset frozen", 32'(frozen), 0);
        check("reset right_out", 32'(right_out), 0);
        reset = 1'b0;
        cyc();

        // grow from NORMAL, then run the full 300-frame power-up
        grow = 1'b1; cyc(); grow = 1'b0;
        check_len_timer("grow", 4, 300, 1);
        frames(299);
        check_len_timer("grow 299 frames", 4, 1, 1);
        frames(1);
        check_len_timer("grow expired", 2, 0, 0);

        // key gating in NORMAL
        right = 1'b1; cyc();
        check("gate right", 32'({right_out, left_out}), 32'b10);
        left = 1'b1; cyc();
        check("gate both", 32'({right_out, left_out}), 32'b00);
        right = 1'b0; cyc();
        check("gate left", 32'({right_out, left_out}), 32'b01);
        left = 1'b0; cyc();

        // shrink while GROWN with 120 frames left
        grow = 1'b1; cyc(); grow = 1'b0;
        frames(180);
        check("grown mid timer", 32'(frames_left), 120);
        shrink = 1'b1; cyc(); shrink = 1'b0;
`ifdef POWERUP_STACK_EN
        check_len_timer("shrink mid grown", 2, 0, 0);
`else
        check_len_timer("shrink mid grown", 0, 300, 1);
`endif
        level_restart = 1'b1; cyc(); level_restart = 1'b0;
        check_len_timer("level_restart", 2, 0, 0);

        // grow and shrink together cancel
        grow = 1'b1; shrink = 1'b1; cyc(); grow = 1'b0; shrink = 1'b0;
        check_len_timer("grow+shrink", 2, 0, 0);

        // shrink to MIN_LEN, then shrink again after 5 frames
        shrink = 1'b1; cyc(); shrink = 1'b0;
        check_len_timer("shrink", 0, 300, 1);
        frames(5);
        shrink = 1'b1; cyc(); shrink = 1'b0;
`ifdef POWERUP_STACK_EN
        check_len_timer("shrink again", 0, 595, 1);
`else
        check_len_timer("shrink again", 0, 300, 1);
`endif
        level_restart = 1'b1; cyc(); level_restart = 1'b0;

        // event and frame tick together: event wins, no decrement
        grow = 1'b1; startOfFrame = 1'b1; cyc(); grow = 1'b0; startOfFrame = 1'b0;
        check_len_timer("grow with tick", 4, 300, 1);

        // ball_lost while GROWN, holding right
        right = 1'b1;
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
        check_len_timer("ball_lost", 2, 60, 0);
        check("ball_lost frozen", 32'(frozen), 1);
        check("ball_lost right_out", 32'(right_out), 0);
        grow = 1'b1; cyc(); grow = 1'b0;
        check_len_timer("grow in freeze", 2, 60, 0);
        frames(59);
        check("freeze 59 timer", 32'(frames_left), 1);
        check("freeze 59 right_out", 32'(right_out), 0);
        check("freeze 59 frozen", 32'(frozen), 1);
        frames(1);
        check("freeze end timer", 32'(frames_left), 0);
        check("freeze end frozen", 32'(frozen), 0);
        check("freeze end right_out", 32'(right_out), 1);
        right = 1'b0; cyc();

        // asynchronous reset between clock edges during FREEZE
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
        frames(10);
        check("freeze 10 timer", 32'(frames_left), 50);
        #2 reset = 1'b1;
        #1;
        check("async reset timer", 32'(frames_left), 0);
        check("async reset frozen", 32'(frozen), 0);
        check("async reset len", 32'(bat_length), 2);
        cyc();
        reset = 1'b0;
        cyc();

        // level_restart beats ball_lost
        grow = 1'b1; cyc(); grow = 1'b0;
        level_restart = 1'b1; ball_lost = 1'b1; cyc(); level_restart = 1'b0; ball_lost = 1'b0;
        check_len_timer("restart vs lost", 2, 0, 0);
        check("restart vs lost frozen", 32'(frozen), 0);

        // two grows back to back
        grow = 1'b1; cyc(); cyc(); grow = 1'b0;
`ifdef POWERUP_STACK_EN
        check_len_timer("double grow", 4, 600, 1);
`else
        check_len_timer("double grow", 4, 300, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
